// File: rtl/aidc_zrl_pkg.sv
// Shared types and constants for the ZRL write-path compressor.
package aidc_zrl_pkg;

    localparam int ZRL_DATA_W     = 64;
    localparam int ZRL_WORD_W     = 32;
    localparam int ZRL_BEATS      = 8;
    localparam int WORDS_PER_LINE = ZRL_BEATS * ZRL_DATA_W / ZRL_WORD_W;
    localparam int COMP_MAX_NZ    = 2 * (ZRL_BEATS - 2);

    typedef enum logic [2:0] {
        FILL,
        DECIDE,
        SEND_HDR,
        SEND_RAW,
        SEND_DATA
    } zrl_state_e;

    // Compressed packet length: one bitmap beat plus ceil(n/2) data beats.
    function automatic logic [3:0] zrl_len(input logic [4:0] n);
        logic [4:0] half;
        half = (n + 5'd1) >> 1;
        return 4'(half + 5'd1);
    endfunction

endpackage

// File: rtl/aidc_zrl_pick2.sv
// Finds the two lowest set bits of a 16-bit word mask.
module aidc_zrl_pick2 (
    input  logic [15:0] mask_i,
    output logic [3:0]  idx0_o,
    output logic [3:0]  idx1_o,
    output logic        v0_o,
    output logic        v1_o
);

    // Priority scan from bit 0 upward; first hit fills slot 0, second fills slot 1.
    always_comb begin
        idx0_o = '0;
        idx1_o = '0;
        v0_o   = 1'b0;
        v1_o   = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (mask_i[i]) begin
                if (!v0_o) begin
                    idx0_o = 4'(i);
                    v0_o   = 1'b1;
                end else if (!v1_o) begin
                    idx1_o = 4'(i);
                    v1_o   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/aidc_comp_zrl.sv
// Zero-word compressor for the write-data path: buffers one line, then emits
// bitmap + packed non-zero words, or the raw line when that would not be shorter.
// Optional statistics counters: define AIDC_ZRL_STAT_EN.
module aidc_comp_zrl
    import aidc_zrl_pkg::*;
#(
    parameter int DATA_W = ZRL_DATA_W,
    parameter int WORD_W = ZRL_WORD_W,
    parameter int BEATS  = ZRL_BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              comp_o,
    output logic [3:0]        len_o,
    output logic              err_o
`ifdef AIDC_ZRL_STAT_EN
    ,
    output logic [31:0]       stat_lines_o,
    output logic [31:0]       stat_saved_o
`endif
);

    localparam int NW = BEATS * DATA_W / WORD_W;
    localparam int CW = $clog2(BEATS);

    zrl_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     raw_idx_q;
    logic [NW-1:0]     bm_q;
    logic [NW-1:0]     rem_q;
    logic [DATA_W-1:0] line_q [BEATS];
    logic              ready_q, valid_q, last_q, comp_q, err_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        len_q;

    logic              in_hs;
    logic              line_end;
    logic [1:0]        nz_pair;
    logic [4:0]        nz_cnt;
    logic              comp_d;
    logic [3:0]        idx0, idx1;
    logic              v0, v1;
    logic [WORD_W-1:0] lo_word, hi_word;
    logic [NW-1:0]     rem_d;

    assign in_hs    = valid_i && ready_q;
    assign line_end = (cnt_q == CW'(BEATS - 1));
    assign nz_pair  = {|data_i[DATA_W-1:WORD_W], |data_i[WORD_W-1:0]};
    assign comp_d   = (nz_cnt <= 5'(COMP_MAX_NZ));

    aidc_zrl_pick2 u_pick2 (
        .mask_i (rem_q),
        .idx0_o (idx0),
        .idx1_o (idx1),
        .v0_o   (v0),
        .v1_o   (v1)
    );

    // Popcount of the line bitmap, consumed in DECIDE.
    always_comb begin
        nz_cnt = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            nz_cnt = nz_cnt + 5'(bm_q[i]);
        end
    end

    // Next packed beat from the remaining mask; rem_q tracks words not yet loaded
    // into the output register, so last_o for a loaded beat is "nothing left".
    always_comb begin
        lo_word = '0;
        hi_word = '0;
        rem_d   = rem_q;
        if (v0) begin
            lo_word = idx0[0] ? line_q[idx0[3:1]][DATA_W-1:WORD_W]
                              : line_q[idx0[3:1]][WORD_W-1:0];
            rem_d[idx0] = 1'b0;
        end
        if (v1) begin
            hi_word = idx1[0] ? line_q[idx1[3:1]][DATA_W-1:WORD_W]
                              : line_q[idx1[3:1]][WORD_W-1:0];
            rem_d[idx1] = 1'b0;
        end
    end

    // Line buffer write; contents need no reset since the bitmap gates their use.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            line_q[cnt_q] <= data_i;
        end
    end

    // Main FSM with registered handshake and packet outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            raw_idx_q <= '0;
            bm_q      <= '0;
            rem_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            comp_q    <= 1'b0;
            len_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                FILL: begin
                    if (in_hs) begin
                        err_q <= (last_i != line_end);
                        bm_q  <= bm_q | (NW'(nz_pair) << {cnt_q, 1'b0});
                        if (line_end) begin
                            cnt_q   <= '0;
                            ready_q <= 1'b0;
                            state_q <= DECIDE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DECIDE: begin
                    comp_q  <= comp_d;
                    len_q   <= comp_d ? zrl_len(nz_cnt) : 4'(BEATS);
                    valid_q <= 1'b1;
                    if (comp_d) begin
                        data_q  <= DATA_W'(bm_q);
                        last_q  <= (nz_cnt == 5'd0);
                        rem_q   <= bm_q;
                        state_q <= SEND_HDR;
                    end else begin
                        data_q    <= line_q[0];
                        last_q    <= 1'b0;
                        raw_idx_q <= CW'(1);
                        state_q   <= SEND_RAW;
                    end
                end
                SEND_HDR, SEND_DATA: begin
                    if (ready_i) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            ready_q <= 1'b1;
                            bm_q    <= '0;
                            state_q <= FILL;
                        end else begin
                            data_q  <= {hi_word, lo_word};
                            last_q  <= (rem_d == '0);
                            rem_q   <= rem_d;
                            state_q <= SEND_DATA;
                        end
                    end
                end
                SEND_RAW: begin
                    if (ready_i) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            ready_q <= 1'b1;
                            bm_q    <= '0;
                            state_q <= FILL;
                        end else begin
                            data_q    <= line_q[raw_idx_q];
                            last_q    <= (raw_idx_q == CW'(BEATS - 1));
                            raw_idx_q <= raw_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef AIDC_ZRL_STAT_EN
    logic [31:0] stat_lines_q, stat_saved_q;

    // Compression statistics, updated once per compressed line in DECIDE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lines_q <= '0;
            stat_saved_q <= '0;
        end else if (state_q == DECIDE && comp_d) begin
            stat_lines_q <= stat_lines_q + 32'd1;
            stat_saved_q <= stat_saved_q + (32'(BEATS) - 32'(zrl_len(nz_cnt)));
        end
    end

    assign stat_lines_o = stat_lines_q;
    assign stat_saved_o = stat_saved_q;
`endif

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign comp_o  = comp_q;
    assign len_o   = len_q;
    assign err_o   = err_q;

endmodule

// File: doc/aidc_comp_zrl.md
Name: aidc_comp_zrl

Overview:
- Zero-word compressor on the write-data path. It is the encoder counterpart of the ZRL decompressor that sits on the read-data path.
- Buffers one full cache-line burst from the core W stream, builds a non-zero-word bitmap, and emits the line either compressed (bitmap beat plus packed non-zero words) or raw.
- Output goes toward memory W. Handles one line at a time; single line buffer.

Parameters:
- DATA_W, 64, beat width in bits; must be 2*WORD_W.
- WORD_W, 32, compression granule in bits.
- BEATS, 8, beats per line; a line is 16 words.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i&&ready_o
- data_i  in  DATA_W  input beat; word 0 is in the low WORD_W bits
- last_i  in  1  input end of burst (AXI WLAST)
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream ready
- data_o  out  DATA_W  output beat
- last_o  out  1  final output beat of the line
- comp_o  out  1  1 means the current packet is compressed; stable for the whole packet
- len_o  out  4  beats in the current packet (1..BEATS); stable for the whole packet
- err_o  out  1  one-cycle pulse on a last_i mismatch

Behaviour:
- Reset (asynchronous, rst_n low): state FILL, beat count 0, bitmap 0, and ready_o=1. valid_o, last_o, comp_o and err_o are 0; data_o=0 and len_o=0. A partially filled line is discarded and nothing is emitted.
- FILL state:
  - ready_o=1, valid_o=0.
  - Each accepted beat is written into buffer slot cnt. Bitmap bits [2cnt] and [2cnt+1] are set where the corresponding word is non-zero. cnt increments.
  - On the beat with cnt==BEATS-1, go to DECIDE. The burst ends at BEATS beats regardless of last_i.
  - err_o pulses if last_i=1 on a beat other than the BEATS-th, or last_i=0 on the BEATS-th. Data is still processed normally.
- DECIDE state (1 cycle):
  - N = popcount(bitmap), 0..16.
  - Compressed length is 1+ceil(N/2). comp = (N<=12), which gives length <= 7 < BEATS. Otherwise raw, with len=BEATS.
  - Latch comp_o and len_o. Go to SEND_HDR if comp, else SEND_RAW.
- SEND_HDR state:
  - valid_o=1, data_o = {zeros, bitmap[15:0]}, last_o=(N==0).
  - On handshake, go to SEND_DATA, or to FILL if last_o.
- SEND_DATA state:
  - A remaining-mask starts as the bitmap.
  - Each beat packs the two lowest-index set words: the lower-index word goes in the low half, the next in the high half. If only one word remains, the high half is 0.
  - Both bits are cleared from the mask on handshake. last_o=1 when the mask holds at most 2 bits.
- SEND_RAW state:
  - Buffer beats 0..BEATS-1 are emitted unchanged; last_o on beat BEATS-1.
- Output handshake: while valid_o=1 and ready_i=0, data_o, last_o, comp_o and len_o hold stable and valid_o stays high.
- After the last handshake, return to FILL with cnt=0 and bitmap=0. comp_o and len_o hold their value until the next DECIDE.
- Latency: first output beat is valid 2 cycles after the last input beat is accepted. ready_o=0 from that acceptance until the packet's final handshake. There is no overlap between consecutive lines.

Optional Feature:
- Macro AIDC_ZRL_STAT_EN.
- When defined, adds outputs stat_lines_o[31:0] and stat_saved_o[31:0]:
  - stat_lines_o counts compressed lines.
  - stat_saved_o accumulates BEATS-len per compressed line.
  - Both update at DECIDE when comp=1, reset to 0, and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package aidc_zrl_pkg holds:
  - the state enum (FILL, DECIDE, SEND_HDR, SEND_RAW, SEND_DATA);
  - WORDS_PER_LINE = BEATS*DATA_W/WORD_W;
  - COMP_MAX_NZ = 2*(BEATS-2);
  - a function zrl_len(N).
- One sub-module: aidc_zrl_pick2. It is combinational and takes a 16-bit mask, returning the indices and valid flags of the two lowest set bits, used by SEND_DATA.

Test Plan:
- All-zero line, 8 beats with last on beat 8 -> one output beat: data_o=0, comp_o=1, len_o=1, last_o=1.
- Line whose only non-zero words are 3 (0xA) and 9 (0xB) -> 2 beats: hdr=0x0208, then {0xB,0xA}; len_o=2, comp_o=1.
- 13 non-zero words (every word except 2, 5, 7) -> raw pass-through: 8 beats identical to input, comp_o=0, len_o=8.
- 12 non-zero words -> len_o=7, comp_o=1. Words appear in ascending index order; the last beat has both halves filled.
- ready_i toggled randomly during a compressed packet -> no beat is lost or duplicated, outputs are stable while stalled, and ready_o=0 throughout.
- last_i asserted on beat 5 -> err_o pulses once; line still completes after 8 beats. Then rst_n asserted mid-SEND_DATA -> valid_o=0 immediately and ready_o=1 after release.
